// File: rtl/alu_input_sequencer.sv
// Button-driven front end for the ALU: synchronizes pb_a/pb_b/pb_op, captures A, B and opcode,
// strobes alu_go and holds the result. Define ALU_SEQ_DEBOUNCE_EN to insert the debouncer.
module alu_input_sequencer #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned OP_W       = 4,
   parameter int unsigned DEB_CYCLES = 16,
   parameter int unsigned ALU_LAT    = 1
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              pb_a,
   input  logic              pb_b,
   input  logic              pb_op,
   input  logic [DATA_W-1:0] sw,
   input  logic [DATA_W-1:0] alu_res,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [OP_W-1:0]   op_code,
   output logic              alu_go,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              seq_err,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Bit order for all button vectors: [0]=A, [1]=B, [2]=OP.
   logic [2:0] w_btn;
   logic [2:0] r_sync1, r_sync2;
   logic [2:0] w_level, r_level_q;
   logic [2:0] w_ev;
   logic       w_multi;

   assign w_btn = {pb_op, pb_b, pb_a};

   always_ff @(posedge Clk) begin
      if (reset) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_level_q <= '0;
      end else begin
         r_sync1   <= w_btn;
         r_sync2   <= r_sync1;
         r_level_q <= w_level;
      end
   end

`ifdef ALU_SEQ_DEBOUNCE_EN
   localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
   logic [CntW-1:0] r_deb_cnt [3];
   logic [2:0]      r_deb;

   always_ff @(posedge Clk) begin
      if (reset) begin
         r_deb <= '0;
         for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_deb_cnt[i] <= '0;
            end else if (r_deb_cnt[i] == CntW'(DEB_CYCLES - 1)) begin
               r_deb[i]     <= r_sync2[i];
               r_deb_cnt[i] <= '0;
            end else begin
               r_deb_cnt[i] <= r_deb_cnt[i] + CntW'(1);
            end
         end
      end
   end

   assign w_level = r_deb;
`else
   assign w_level = r_sync2;
`endif

   assign w_ev    = w_level & ~r_level_q;
   assign w_multi = (w_ev[0] & w_ev[1]) | (w_ev[0] & w_ev[2]) | (w_ev[1] & w_ev[2]);

   state_t            r_state, w_state_n;
   logic [DATA_W-1:0] r_op_a, w_op_a_n, r_op_b, w_op_b_n, r_res, w_res_n;
   logic [OP_W-1:0]   r_op_code, w_op_code_n;
   logic [3:0]        r_lat, w_lat_n;
   logic              r_go, w_go_n, r_valid, w_valid_n, r_err, w_err_n;

   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state   <= S_A;
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_op_code <= '0;
         r_res     <= '0;
         r_lat     <= '0;
         r_go      <= 1'b0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_op_a    <= w_op_a_n;
         r_op_b    <= w_op_b_n;
         r_op_code <= w_op_code_n;
         r_res     <= w_res_n;
         r_lat     <= w_lat_n;
         r_go      <= w_go_n;
         r_valid   <= w_valid_n;
         r_err     <= w_err_n;
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_op_a_n    = r_op_a;
      w_op_b_n    = r_op_b;
      w_op_code_n = r_op_code;
      w_res_n     = r_res;
      w_lat_n     = r_lat;
      w_go_n      = 1'b0;
      w_valid_n   = r_valid;
      w_err_n     = 1'b0;

      if (r_state == S_EXEC) begin
         // Presses are ignored here; only the latency counter advances.
         if (r_lat == 4'(ALU_LAT)) begin
            w_res_n   = alu_res;
            w_valid_n = 1'b1;
            w_state_n = S_DONE;
         end else begin
            w_lat_n = r_lat + 4'd1;
         end
      end else if (w_multi) begin
         w_err_n = 1'b1;
      end else begin
         unique case (r_state)
            S_A: begin
               if (w_ev[0]) begin
                  w_op_a_n  = sw;
                  w_state_n = S_B;
               end else if (w_ev[1] || w_ev[2]) begin
                  w_err_n = 1'b1;
               end
            end
            S_B: begin
               if (w_ev[0]) begin
                  w_op_a_n = sw;
               end else if (w_ev[1]) begin
                  w_op_b_n  = sw;
                  w_state_n = S_OP;
               end else if (w_ev[2]) begin
                  w_err_n = 1'b1;
               end
            end
            S_OP: begin
               if (w_ev[0]) begin
                  w_op_a_n = sw;
               end else if (w_ev[1]) begin
                  w_op_b_n = sw;
               end else if (w_ev[2]) begin
                  w_op_code_n = sw[OP_W-1:0];
                  w_state_n   = S_EXEC;
               end
            end
            S_DONE: begin
               if (w_ev[0]) begin
                  w_op_a_n  = sw;
                  w_valid_n = 1'b0;
                  w_state_n = S_B;
               end else if (w_ev[2]) begin
                  w_op_code_n = sw[OP_W-1:0];
                  w_valid_n   = 1'b0;
                  w_state_n   = S_EXEC;
               end else if (w_ev[1]) begin
                  w_err_n = 1'b1;
               end
            end
            default: w_state_n = S_A;
         endcase
      end

      if (w_state_n == S_EXEC && r_state != S_EXEC) begin
         w_go_n  = 1'b1;
         w_lat_n = '0;
      end
   end

   assign op_a         = r_op_a;
   assign op_b         = r_op_b;
   assign op_code      = r_op_code;
   assign alu_go       = r_go;
   assign result       = r_res;
   assign result_valid = r_valid;
   assign seq_err      = r_err;
   assign state        = r_state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Self-checking bench for alu_input_sequencer: transaction-level model of the capture sequence
// plus a bench ALU that only presents a correct alu_res exactly ALU_LAT cycles after alu_go.
module tb_alu_input_sequencer;

   localparam int unsigned ALU_LAT = 1;
   localparam logic [2:0]  MA = 3'b001;
   localparam logic [2:0]  MB = 3'b010;
   localparam logic [2:0]  MO = 3'b100;

   logic       Clk = 1'b0;
   logic       reset = 1'b1;
   logic       pb_a = 1'b0, pb_b = 1'b0, pb_op = 1'b0;
   logic [7:0] sw = '0;
   logic [7:0] alu_res;
   logic [7:0] op_a, op_b, result;
   logic [3:0] op_code;
   logic       alu_go, result_valid, seq_err;
   logic [2:0] state;

   alu_input_sequencer #(.ALU_LAT(ALU_LAT)) dut (
      .Clk(Clk), .reset(reset), .pb_a(pb_a), .pb_b(pb_b), .pb_op(pb_op), .sw(sw),
      .alu_res(alu_res), .op_a(op_a), .op_b(op_b), .op_code(op_code), .alu_go(alu_go),
      .result(result), .result_valid(result_valid), .seq_err(seq_err), .state(state)
   );

   always #5 Clk = ~Clk;

   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
      case (op)
         4'd1:    return a + b;
         4'd2:    return a - b;
         default: return a ^ b;
      endcase
   endfunction

   // Bench ALU: wrong value on every cycle except the one the DUT must sample.
   int         lat_cnt = 0;
   logic [7:0] alu_good = '0;
   logic [7:0] noise = 8'h5A;
   always @(posedge Clk) begin
      noise <= 8'($urandom_range(255, 1));
      if (alu_go === 1'b1) begin
         lat_cnt  <= 1;
         alu_good <= alu_fn(op_a, op_b, op_code);
      end else if (lat_cnt != 0 && lat_cnt < 100) begin
         lat_cnt <= lat_cnt + 1;
      end
   end
   assign alu_res = (lat_cnt == ALU_LAT) ? alu_good : (alu_good ^ noise);

   int go_cnt = 0, err_cnt = 0, err_run = 0, err_max = 0, inv_cnt = 0;
   always @(negedge Clk) begin
      if (alu_go === 1'b1) go_cnt <= go_cnt + 1;
      if (result_valid === 1'b0) inv_cnt <= inv_cnt + 1;
      if (seq_err === 1'b1) begin
         err_cnt <= err_cnt + 1;
         err_run <= err_run + 1;
         if (err_run + 1 > err_max) err_max <= err_run + 1;
      end else begin
         err_run <= 0;
      end
   end

   int n_checks = 0, n_pass = 0;

   int         m_state = 0;
   logic [7:0] m_a = '0, m_b = '0, m_res = '0;
   logic [3:0] m_op = '0;
   logic       m_valid = 1'b0;

   task automatic model_reset();
      m_state = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_valid = 1'b0;
   endtask

   task automatic model_run(input logic [7:0] s, output int e_go);
      m_op    = s[3:0];
      m_res   = alu_fn(m_a, m_b, m_op);
      m_valid = 1'b1;
      m_state = 4;
      e_go    = 1;
   endtask

   task automatic model_press(input logic [2:0] m, input logic [7:0] s,
                              output int e_err, output int e_go);
      e_err = 0;
      e_go  = 0;
      if ($countones(m) > 1) begin
         e_err = 1;
         return;
      end
      case (m_state)
         0: if (m == MA) begin m_a = s; m_state = 1; end else e_err = 1;
         1: if (m == MA) m_a = s;
            else if (m == MB) begin m_b = s; m_state = 2; end
            else e_err = 1;
         2: if (m == MA) m_a = s;
            else if (m == MB) m_b = s;
            else model_run(s, e_go);
         4: if (m == MA) begin m_a = s; m_valid = 1'b0; m_state = 1; end
            else if (m == MO) model_run(s, e_go);
            else e_err = 1;
         default: ;
      endcase
   endtask

   task automatic drive_press(input logic [2:0] m, input logic [7:0] s, input int hold);
      sw = s;
      {pb_op, pb_b, pb_a} = m;
      repeat (hold) @(negedge Clk);
      {pb_op, pb_b, pb_a} = '0;
      repeat (30) @(negedge Clk);
   endtask

   task automatic test_reset();
      int e0;
      reset = 1'b1;
      repeat (25) @(negedge Clk);
      reset = 1'b0;
      model_reset();
      @(negedge Clk);
      n_checks++;
      if ({op_a, op_b, op_code, alu_go, result, result_valid, seq_err, state} !== '0)
         $display("FAIL reset_outputs: got %h required 0",
                  {op_a, op_b, op_code, alu_go, result, result_valid, seq_err, state});
      else n_pass++;
      e0 = err_cnt;
      drive_press(MO, 8'h00, 30);
      n_checks++;
      if (err_cnt - e0 !== 1) $display("FAIL reset_op_err: got %0d required 1", err_cnt - e0);
      else n_pass++;
      n_checks++;
      if (state !== 3'd0) $display("FAIL reset_op_state: got %0d required 0", state);
      else n_pass++;
      n_checks++;
      if (err_max !== 1) $display("FAIL seq_err_width: got %0d required 1", err_max);
      else n_pass++;
   endtask

   task automatic test_glitch();
`ifdef ALU_SEQ_DEBOUNCE_EN
      int e0, ee, eg;
      e0 = err_cnt;
      sw = 8'h33;
      for (int i = 0; i < 20; i++) begin
         pb_a = ~pb_a;
         repeat (5) @(negedge Clk);
      end
      pb_a = 1'b0;
      repeat (30) @(negedge Clk);
      n_checks++;
      if (state !== 3'd0 || op_a !== 8'h00)
         $display("FAIL glitch_reject: got state %0d op_a %h required 0 00", state, op_a);
      else n_pass++;
      model_press(MA, 8'h0F, ee, eg);
      drive_press(MA, 8'h0F, 20);
      n_checks++;
      if (state !== 3'(m_state) || op_a !== m_a || err_cnt - e0 !== ee)
         $display("FAIL glitch_clean_press: got state %0d op_a %h required %0d %h",
                  state, op_a, m_state, m_a);
      else n_pass++;
`endif
   endtask

   task automatic test_normal();
      int ee, eg, g0;
      g0 = go_cnt;
      model_press(MA, 8'h0F, ee, eg);
      drive_press(MA, 8'h0F, 25);
      n_checks++;
      if (op_a !== 8'h0F || state !== 3'(m_state))
         $display("FAIL normal_a: got op_a %h state %0d required 0f %0d", op_a, state, m_state);
      else n_pass++;
      model_press(MB, 8'h05, ee, eg);
      drive_press(MB, 8'h05, 25);
      n_checks++;
      if (op_b !== 8'h05 || state !== 3'd2)
         $display("FAIL normal_b: got op_b %h state %0d required 05 2", op_b, state);
      else n_pass++;
      model_press(MO, 8'h01, ee, eg);
      drive_press(MO, 8'h01, 25);
      n_checks++;
      if (op_code !== 4'd1) $display("FAIL normal_opcode: got %h required 1", op_code);
      else n_pass++;
      n_checks++;
      if (go_cnt - g0 !== 1) $display("FAIL normal_go_count: got %0d required 1", go_cnt - g0);
      else n_pass++;
      n_checks++;
      if (result !== 8'h14 || result !== m_res)
         $display("FAIL normal_result: got %h required 14", result);
      else n_pass++;
      n_checks++;
      if (result_valid !== 1'b1 || state !== 3'd4)
         $display("FAIL normal_done: got valid %b state %0d required 1 4", result_valid, state);
      else n_pass++;
   endtask

   task automatic test_hold_once();
      int ee, eg, e0;
      e0 = err_cnt;
      model_press(MB, 8'h44, ee, eg);
      drive_press(MB, 8'h44, 80);
      n_checks++;
      if (err_cnt - e0 !== ee || state !== 3'(m_state))
         $display("FAIL hold_once: got errs %0d state %0d required %0d %0d",
                  err_cnt - e0, state, ee, m_state);
      else n_pass++;
   endtask

   task automatic test_rerun();
      int ee, eg, g0, i0;
      g0 = go_cnt;
      i0 = inv_cnt;
      model_press(MO, 8'h02, ee, eg);
      drive_press(MO, 8'h02, 25);
      n_checks++;
      if (inv_cnt - i0 < 1) $display("FAIL rerun_valid_drop: got %0d required >=1", inv_cnt - i0);
      else n_pass++;
      n_checks++;
      if (go_cnt - g0 !== 1) $display("FAIL rerun_go_count: got %0d required 1", go_cnt - g0);
      else n_pass++;
      n_checks++;
      if (result !== 8'h0A || result !== m_res || result_valid !== 1'b1)
         $display("FAIL rerun_result: got %h valid %b required 0a 1", result, result_valid);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      int ee, eg, e0;
      model_press(MA, 8'h21, ee, eg);
      drive_press(MA, 8'h21, 25);
      e0 = err_cnt;
      model_press(MA | MB, 8'h77, ee, eg);
      drive_press(MA | MB, 8'h77, 25);
      n_checks++;
      if (err_cnt - e0 !== 1) $display("FAIL simul_err: got %0d required 1", err_cnt - e0);
      else n_pass++;
      n_checks++;
      if (op_a !== 8'h21 || op_b !== m_b || state !== 3'd1)
         $display("FAIL simul_hold: got a %h b %h state %0d required 21 %h 1", op_a, op_b,
                  state, m_b);
      else n_pass++;
   endtask

   task automatic test_reset_in_exec();
      int ee, eg, g0, t;
      model_press(MB, 8'h09, ee, eg);
      drive_press(MB, 8'h09, 25);
      g0 = go_cnt;
      sw = 8'h01;
      pb_op = 1'b1;
      t = 0;
      while (alu_go !== 1'b1 && t < 60) begin
         @(negedge Clk);
         t++;
      end
      n_checks++;
      if (alu_go !== 1'b1) $display("FAIL exec_go_seen: got %b required 1 within 60", alu_go);
      else n_pass++;
      reset = 1'b1;
      pb_op = 1'b0;
      @(negedge Clk);
      n_checks++;
      if (state !== 3'd0 || result_valid !== 1'b0 || result !== 8'h00)
         $display("FAIL exec_reset: got state %0d valid %b result %h required 0 0 00",
                  state, result_valid, result);
      else n_pass++;
      repeat (25) @(negedge Clk);
      reset = 1'b0;
      model_reset();
      repeat (30) @(negedge Clk);
      n_checks++;
      if (go_cnt - g0 !== 1 || state !== 3'd0)
         $display("FAIL exec_no_go_after_reset: got gos %0d state %0d required 1 0",
                  go_cnt - g0, state);
      else n_pass++;
   endtask

   task automatic test_random();
      int ee, eg, e0, g0;
      logic [2:0] m;
      logic [7:0] s;
      for (int it = 0; it < 16; it++) begin
         case ($urandom_range(5, 0))
            0, 1:    m = MA;
            2:       m = MB;
            3, 4:    m = MO;
            default: m = MB | MO;
         endcase
         s  = 8'($urandom);
         e0 = err_cnt;
         g0 = go_cnt;
         model_press(m, s, ee, eg);
         drive_press(m, s, int'($urandom_range(40, 20)));
         n_checks++;
         if (state !== 3'(m_state)) $display("FAIL rnd_state: got %0d required %0d", state, m_state);
         else n_pass++;
         n_checks++;
         if (op_a !== m_a) $display("FAIL rnd_op_a: got %h required %h", op_a, m_a);
         else n_pass++;
         n_checks++;
         if (op_b !== m_b) $display("FAIL rnd_op_b: got %h required %h", op_b, m_b);
         else n_pass++;
         n_checks++;
         if (op_code !== m_op) $display("FAIL rnd_op_code: got %h required %h", op_code, m_op);
         else n_pass++;
         n_checks++;
         if (result !== m_res) $display("FAIL rnd_result: got %h required %h", result, m_res);
         else n_pass++;
         n_checks++;
         if (result_valid !== m_valid)
            $display("FAIL rnd_valid: got %b required %b", result_valid, m_valid);
         else n_pass++;
         n_checks++;
         if (err_cnt - e0 !== ee) $display("FAIL rnd_err: got %0d required %0d", err_cnt - e0, ee);
         else n_pass++;
         n_checks++;
         if (go_cnt - g0 !== eg) $display("FAIL rnd_go: got %0d required %0d", go_cnt - g0, eg);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_normal();
      test_hold_once();
      test_rerun();
      test_simultaneous();
      test_reset_in_exec();
      test_random();
      n_checks++;
      if (err_max !== 1) $display("FAIL seq_err_width_final: got %0d required 1", err_max);
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
